// File: rtl/axilite_csr_write_channel.sv
// ============================================================================
// axilite_csr_write_channel: AXI4-Lite slave write path (AW/W/B) into a CSR bank.
// Optional macro CSR_WRITE_PROTECT_EN adds RO_MASK and a global lock input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axilite_csr_write_channel #(
    parameter int                              NUM_REGS    = 4,
    parameter int                              DATA_WIDTH  = 32,
    parameter int                              ADDR_SIZE   = 32,
    parameter logic [ADDR_SIZE-1:0]            BASE_ADDR   = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VALUE = '0,
    parameter logic [1:0]                      RESP_OKAY   = 2'd0,
    parameter logic [1:0]                      RESP_SLVERR = 2'd2
`ifdef CSR_WRITE_PROTECT_EN
    ,parameter logic [NUM_REGS-1:0]            RO_MASK     = '0
`endif
) (
`ifdef CSR_WRITE_PROTECT_EN
    input  logic                               lock,
`endif
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_SIZE-1:0]               awaddr,
    input  logic                               awvalid,
    output logic                               awready,
    input  logic [DATA_WIDTH-1:0]              wdata,
    input  logic [DATA_WIDTH/8-1:0]            wstrb,
    input  logic                               wvalid,
    output logic                               wready,
    output logic [1:0]                         bresp,
    output logic                               bvalid,
    input  logic                               bready,
    output logic [NUM_REGS*DATA_WIDTH-1:0]     regs,
    output logic [NUM_REGS-1:0]                wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SHIFT  = $clog2(STRB_W);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HAVE_AW = 3'd1,
        HAVE_W  = 3'd2,
        COMMIT  = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [STRB_W-1:0]      strb_q;
    logic [ADDR_SIZE-1:0]   offset;
    logic [ADDR_SIZE-1:0]   word_idx;
    logic                   in_range;
    logic                   write_ok;
    logic                   aw_hs;
    logic                   w_hs;

    always_comb begin
        state_next = state;
        awready    = 1'b0;
        wready     = 1'b0;
        case (state)
            IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
                if (awvalid && wvalid) state_next = COMMIT;
                else if (awvalid)      state_next = HAVE_AW;
                else if (wvalid)       state_next = HAVE_W;
            end
            HAVE_AW: begin
                wready = 1'b1;
                if (wvalid) state_next = COMMIT;
            end
            HAVE_W: begin
                awready = 1'b1;
                if (awvalid) state_next = COMMIT;
            end
            COMMIT:  state_next = RESP;
            RESP:    if (bready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Below-base addresses are caught by the compare, never by the wrapped offset.
    assign offset   = addr_q - BASE_ADDR;
    assign word_idx = offset >> SHIFT;
    assign in_range = (addr_q >= BASE_ADDR) && (word_idx < ADDR_SIZE'(NUM_REGS));

`ifdef CSR_WRITE_PROTECT_EN
    logic ro_hit;
    always_comb begin
        ro_hit = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (word_idx == ADDR_SIZE'(k) && RO_MASK[k]) ro_hit = 1'b1;
        end
    end
    assign write_ok = in_range && !lock && !ro_hit;
`else
    assign write_ok = in_range;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            wr_pulse <= '0;
            regs     <= RESET_VALUE;
        end else begin
            state    <= state_next;
            wr_pulse <= '0;
            if (aw_hs) addr_q <= awaddr;
            if (w_hs) begin
                data_q <= wdata;
                strb_q <= wstrb;
            end
            if (state == COMMIT) begin
                bvalid <= 1'b1;
                bresp  <= write_ok ? RESP_OKAY : RESP_SLVERR;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (write_ok && word_idx == ADDR_SIZE'(k)) begin
                        // Pulse fires even with an all-zero strobe.
                        wr_pulse[k] <= 1'b1;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (strb_q[b]) regs[k*DATA_WIDTH + b*8 +: 8] <= data_q[b*8 +: 8];
                        end
                    end
                end
            end else if (state == RESP && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axilite_csr_write_channel.sv
// Self-checking bench for axilite_csr_write_channel (4 x 32-bit bank, base 0).
`default_nettype none

module tb_axilite_csr_write_channel;

    localparam logic [127:0] RV = {32'hCAFE0003, 32'h00000000, 32'h00000000, 32'h00001000};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  awaddr = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [127:0] regs;
    logic [3:0]   wr_pulse;
`ifdef CSR_WRITE_PROTECT_EN
    logic         lock = 1'b0;
`endif

    axilite_csr_write_channel #(
        .NUM_REGS(4), .DATA_WIDTH(32), .ADDR_SIZE(32), .BASE_ADDR(32'h0),
        .RESET_VALUE(RV), .RESP_OKAY(2'd0), .RESP_SLVERR(2'd2)
`ifdef CSR_WRITE_PROTECT_EN
        , .RO_MASK(4'b0001)
`endif
    ) dut (
`ifdef CSR_WRITE_PROTECT_EN
        .lock(lock),
`endif
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .regs(regs), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          mode;   // 0 same cycle, 1 AW first, 2 W first
        int          bp;     // cycles of bready low after bvalid
        logic [1:0]  resp;
        logic [3:0]  pulse;
    } vec_t;

    typedef struct {
        logic [1:0]   resp;
        logic [3:0]   pulse;
        logic [127:0] regs;
    } sb_t;

    vec_t         tbl[7];
    sb_t          sb_q[$];
    logic [127:0] model;
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input vec_t t, input bit blocked);
        sb_t e;
        int  idx;
        if (!blocked && t.addr < 32'h10) begin
            idx = int'(t.addr[3:2]);
            for (int b = 0; b < 4; b++)
                if (t.strb[b]) model[idx*32 + b*8 +: 8] = t.data[b*8 +: 8];
        end
        e.resp = t.resp; e.pulse = t.pulse; e.regs = model;
        sb_q.push_back(e);

        awaddr = t.addr; wdata = t.data; wstrb = t.strb;
        if (t.mode == 0) begin
            awvalid = 1'b1; wvalid = 1'b1;
            for (int i = 0; i < 20 && !(awready && wready); i++) tick();
            check("idle_ready", {awready, wready}, 2'b11);
            tick();
            awvalid = 1'b0; wvalid = 1'b0;
        end else if (t.mode == 1) begin
            awvalid = 1'b1;
            for (int i = 0; i < 20 && !awready; i++) tick();
            check("aw_ready", awready, 1'b1);
            tick();
            awvalid = 1'b0;
            repeat (3) begin
                tick();
                check("have_aw_ready", {awready, wready}, 2'b01);
            end
            wvalid = 1'b1;
            tick();
            wvalid = 1'b0;
        end else begin
            wvalid = 1'b1;
            for (int i = 0; i < 20 && !wready; i++) tick();
            check("w_ready", wready, 1'b1);
            tick();
            wvalid = 1'b0;
            repeat (3) begin
                tick();
                check("have_w_ready", {awready, wready}, 2'b10);
            end
            awvalid = 1'b1;
            tick();
            awvalid = 1'b0;
        end

        check("commit_bvalid", bvalid, 1'b0);
        check("commit_ready", {awready, wready}, 2'b00);
        tick();
        check("latency_bvalid", bvalid, 1'b1);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            e = sb_q.pop_front();
            check("bresp", bresp, e.resp);
            check("wr_pulse", wr_pulse, e.pulse);
            check("regs", regs, e.regs);
        end
        repeat (t.bp) begin
            tick();
            check("bp_bvalid", bvalid, 1'b1);
            check("bp_bresp", bresp, e.resp);
            check("bp_ready", {awready, wready}, 2'b00);
            check("bp_pulse", wr_pulse, 4'b0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("post_b_bvalid", bvalid, 1'b0);
        check("post_b_pulse", wr_pulse, 4'b0);
        check("post_b_ready", {awready, wready}, 2'b11);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0] = '{32'h4,        32'hDEADBEEF, 4'hF, 0, 0, 2'd0, 4'b0010};
        tbl[1] = '{32'h8,        32'h11223344, 4'h5, 2, 0, 2'd0, 4'b0100};
        tbl[2] = '{32'h10,       32'h12345678, 4'hF, 0, 0, 2'd2, 4'b0000};
        tbl[3] = '{32'hC,        32'h55667788, 4'hA, 1, 5, 2'd0, 4'b1000};
        tbl[4] = '{32'h2,        32'hAABBCCDD, 4'h0, 0, 0, 2'd0, 4'b0001};
        tbl[5] = '{32'h7,        32'h00009999, 4'h3, 1, 1, 2'd0, 4'b0010};
        tbl[6] = '{32'hFFFFFFFC, 32'h0BADF00D, 4'hF, 2, 2, 2'd2, 4'b0000};
        model = RV;

        repeat (2) @(posedge clk);
        #1;
        check("rst_regs", regs, RV);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_bresp", bresp, 2'd0);
        check("rst_pulse", wr_pulse, 4'b0);
        check("rst_ready", {awready, wready}, 2'b11);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) do_txn(tbl[i], 1'b0);
        check("final_reg2", regs[64 +: 32], 32'h00220044);
        check("final_reg3", regs[96 +: 32], 32'h55FE7703);
        check("final_reg1", regs[32 +: 32], 32'hDEAD9999);

`ifdef CSR_WRITE_PROTECT_EN
        v = '{32'h0, 32'hFFFFFFFF, 4'hF, 0, 0, 2'd2, 4'b0000};
        do_txn(v, 1'b1);
        lock = 1'b1;
        v = '{32'hC, 32'h01020304, 4'hF, 1, 0, 2'd2, 4'b0000};
        do_txn(v, 1'b1);
        lock = 1'b0;
`else
        v = '{32'h0, 32'hFFFFFFFF, 4'hF, 0, 0, 2'd0, 4'b0001};
        do_txn(v, 1'b0);
`endif

        // Async reset while the response is pending.
        awaddr = 32'h8; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("rr_bvalid_before", bvalid, 1'b1);
        check("rr_reg2_written", regs[64 +: 32], 32'hFFFFFFFF);
        #2 rst = 1'b0;
        #1;
        check("rr_bvalid", bvalid, 1'b0);
        check("rr_regs", regs, RV);
        check("rr_pulse", wr_pulse, 4'b0);
        model = RV;
        tick();
        rst = 1'b1;
        tick();
        check("rr_ready", {awready, wready}, 2'b11);
        check("rr_bresp", bresp, 2'd0);
        v = '{32'h8, 32'h11223344, 4'h5, 0, 0, 2'd0, 4'b0100};
        do_txn(v, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axilite_csr_write_channel.md
Name: axilite_csr_write_channel

Overview:
- Complete AXI4-Lite slave write path (AW, W and B channels) into a parametrised CSR bank.
- AW and W may arrive in either order or in the same cycle. Each is captured independently.
- Writes use byte strobes. Address range is checked. B responses support backpressure. Each register gets a one-cycle write pulse.
- Sits between the AXI-Lite interconnect and the coprocessor control registers. The read channel is a separate block and reads `regs` directly.

Parameters:
- NUM_REGS, 4, number of CSR words (>=1).
- DATA_WIDTH, 32, bus and register width. Must be 32 or 64.
- ADDR_SIZE, 32, AXI address width.
- BASE_ADDR, 0, byte address of reg 0. Must be aligned to DATA_WIDTH/8.
- RESET_VALUE, 0, NUM_REGS*DATA_WIDTH-bit reset image of the bank.
- RESP_OKAY, 0, B response code.
- RESP_SLVERR, 2, B response code.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- awaddr  in  ADDR_SIZE  write address.
- awvalid  in  1  address valid.
- awready  out  1  address ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte strobes.
- wvalid  in  1  data valid.
- wready  out  1  data ready.
- bresp  out  2  write response.
- bvalid  out  1  response valid.
- bready  in  1  response ready.
- regs  out  NUM_REGS*DATA_WIDTH  flattened register bank; reg k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse  out  NUM_REGS  one-hot; bit k high for exactly one cycle when reg k is written.

Behaviour:
- Reset (rst low, async):
  - regs = RESET_VALUE.
  - awready = wready = 1.
  - bvalid = 0, bresp = RESP_OKAY, wr_pulse = 0.
  - Internal holding registers are cleared; the FSM goes to IDLE.
- Reset asserted mid-transaction drops any pending AW, W or B state. No partial write is committed.
- FSM states: IDLE, HAVE_AW, HAVE_W, COMMIT, RESP.
  - IDLE: awready = wready = 1.
    - awvalid & wvalid -> capture both, go to COMMIT.
    - awvalid only -> capture address, go to HAVE_AW.
    - wvalid only -> capture data and strobes, go to HAVE_W.
  - HAVE_AW: awready = 0, wready = 1. wvalid -> capture data, go to COMMIT.
  - HAVE_W: wready = 0, awready = 1. awvalid -> capture address, go to COMMIT.
  - COMMIT: awready = wready = 0.
    - Decode the address and apply the write.
    - Assert bvalid with bresp on the next edge; go to RESP.
  - RESP: bvalid = 1 and bresp is held stable until bready.
    - On bvalid & bready, deassert bvalid and return to IDLE.
    - awready and wready stay 0 in RESP: one outstanding transaction only.
- Latency: AW and W both accepted in cycle N -> register updated at the end of COMMIT (N+1) -> bvalid high from N+2.
- Minimum throughput: one transaction per 3 cycles when bready is held high.
- Decode:
  - offset = awaddr - BASE_ADDR.
  - index = offset >> log2(DATA_WIDTH/8). Low address bits are ignored, giving a word-aligned write.
  - Valid when awaddr >= BASE_ADDR and index < NUM_REGS.
  - Subtraction is done at ADDR_SIZE width; awaddr < BASE_ADDR is detected by explicit compare, not by wrap-around.
- Valid address: for each i with wstrb[i]=1, byte i of reg[index] = wdata byte i. Other bytes keep their value. bresp = RESP_OKAY. wr_pulse[index] is high during the cycle after COMMIT, even if wstrb = 0.
- Invalid address: no register changes, wr_pulse stays 0, bresp = RESP_SLVERR.
- Only registered values are used; bus inputs are never sampled outside their handshake cycle.

Optional Feature:
- Macro CSR_WRITE_PROTECT_EN.
- Defined:
  - Adds parameter RO_MASK (NUM_REGS bits, default 0) and input port lock (1 bit).
  - A write to reg k with RO_MASK[k]=1 is a read-only register: no update, no wr_pulse, RESP_SLVERR.
  - When lock=1 (sampled in COMMIT), every write is refused the same way.
- Not defined: the parameter and port do not exist, and every in-range write succeeds.

Test Plan:
- Same-cycle AW+W: awaddr=0x4, wdata=0xDEADBEEF, wstrb=0xF -> reg1 = 0xDEADBEEF; wr_pulse = 4'b0010 for 1 cycle; bvalid 2 cycles after the handshake; bresp = 0.
- W before AW by 3 cycles, then wstrb=0x5, wdata=0x11223344 to reg2 (reset value 0) -> reg2 = 0x00220044; wready low while waiting for AW.
- Out of range: awaddr = 0x10 with NUM_REGS=4 -> bresp = 2; regs unchanged; wr_pulse = 0.
- Backpressure: bready held low for 5 cycles -> bvalid and bresp stable; awready = wready = 0 throughout; a second AW is accepted only after the B handshake.
- Async reset asserted while in RESP -> bvalid = 0 immediately; regs = RESET_VALUE; awready = wready = 1 after release.
- With CSR_WRITE_PROTECT_EN and RO_MASK=4'b0001: write 0xFFFFFFFF to reg0 -> reg0 unchanged, bresp = 2. With lock=1, a write to reg3 -> refused with bresp = 2.
